meta_intf_wrr_arbiter: RTL and testbench

// N-to-1 arbiter for metaIntf streams with a buffered FIFO per input and weighted round-robin (WRR) or fixed-priority selection.

---
 rtl/meta_intf_wrr_arbiter_pkg.sv | 11 +
 rtl/meta_intf_wrr_arbiter_if.sv | 13 +
 rtl/meta_intf_wrr_arbiter_fifo.sv | 48 ++++
 rtl/meta_intf_wrr_arbiter.sv | 115 +++++++++++
 tb/tb_meta_intf_wrr_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/meta_intf_wrr_arbiter_pkg.sv
// Shared types for the metaIntf N-to-1 arbiter: arbitration mode and default burst weight.
package stf_arb_pkg;

  typedef enum logic {
    ARB_WRR  = 1'b0,
    ARB_PRIO = 1'b1
  } arb_mode_t;

  localparam int ARB_DEFAULT_WEIGHT = 1;

endpackage

// File: rtl/meta_intf_wrr_arbiter_if.sv
// metaIntf stream: valid/ready handshake carrying one STYPE payload per beat.
interface metaIntf #(
  parameter type STYPE = logic [63:0]
);

  logic valid;
  logic ready;
  STYPE data;

  modport m (output valid, output data, input ready);
  modport s (input valid, input data, output ready);

endinterface

// File: rtl/meta_intf_wrr_arbiter_fifo.sv
// Synchronous show-ahead FIFO; head is combinationally visible whenever not empty.
module meta_fifo #(
  parameter type STYPE = logic [63:0],
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  STYPE i_data,
  output logic o_full,
  output logic o_empty,
  output STYPE o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  STYPE             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/meta_intf_wrr_arbiter.sv
// N-to-1 metaIntf merger: per-input FIFOs, weighted round-robin or fixed-priority pick, registered output.
module meta_intf_wrr_arbiter
  import stf_arb_pkg::*;
#(
  parameter int  N_INTERFACES = 4,
  parameter type STYPE        = logic [63:0],
  parameter int  BUF_DEPTH    = 4,
  parameter int  WEIGHT_BITS  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  metaIntf.s                                   intf_in [N_INTERFACES],
  metaIntf.m                                   intf_out,
  input  arb_mode_t                            mode,
  input  logic [N_INTERFACES*WEIGHT_BITS-1:0]  weights,
  output logic [$clog2(N_INTERFACES)-1:0]      grant_id,
  output logic [N_INTERFACES-1:0]              buf_empty
);

  localparam int ID_W = $clog2(N_INTERFACES);

  logic [N_INTERFACES-1:0] w_full;
  logic [N_INTERFACES-1:0] w_empty;
  logic [N_INTERFACES-1:0] w_pop;
  STYPE                    w_head [N_INTERFACES];
  logic                    w_adv;
  logic                    w_found;
  logic [ID_W-1:0]         w_sel;
  logic [WEIGHT_BITS-1:0]  w_next_credit;

  logic [ID_W-1:0]         r_owner;
  logic [WEIGHT_BITS-1:0]  r_credit;
  logic [ID_W-1:0]         r_grant_id;
  logic                    r_valid;
  STYPE                    r_data;

  // A weight of zero behaves as the default burst of one beat.
  function automatic logic [WEIGHT_BITS-1:0] burst_credit(input logic [WEIGHT_BITS-1:0] w);
    return (w == '0) ? WEIGHT_BITS'(ARB_DEFAULT_WEIGHT - 1) : w - 1'b1;
  endfunction

  for (genvar g = 0; g < N_INTERFACES; g++) begin : g_in
    meta_fifo #(.STYPE(STYPE), .DEPTH(BUF_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (intf_in[g].valid && !w_full[g]),
      .i_pop   (w_pop[g]),
      .i_data  (intf_in[g].data),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_head  (w_head[g])
    );
    assign intf_in[g].ready = !w_full[g];
    assign w_pop[g]         = w_adv && w_found && (w_sel == ID_W'(g));
  end

  assign w_adv = !r_valid || intf_out.ready;

  // Selection: priority scan, burst continuation, or cyclic search from owner+1.
  always_comb begin
    w_found       = 1'b0;
    w_sel         = '0;
    w_next_credit = '0;
    if (mode == ARB_PRIO) begin
      for (int i = N_INTERFACES - 1; i >= 0; i--) begin
        if (!w_empty[ID_W'(i)]) begin
          w_found = 1'b1;
          w_sel   = ID_W'(i);
        end
      end
    end else if ((r_credit != '0) && !w_empty[r_owner]) begin
      w_found       = 1'b1;
      w_sel         = r_owner;
      w_next_credit = r_credit - 1'b1;
    end else begin
      for (int k = N_INTERFACES; k >= 1; k--) begin
        if (!w_empty[ID_W'((int'(r_owner) + k) % N_INTERFACES)]) begin
          w_found = 1'b1;
          w_sel   = ID_W'((int'(r_owner) + k) % N_INTERFACES);
        end
      end
      w_next_credit = burst_credit(weights[int'(w_sel)*WEIGHT_BITS +: WEIGHT_BITS]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_grant_id <= '0;
      r_owner    <= ID_W'(N_INTERFACES - 1);
      r_credit   <= '0;
    end else if (w_adv) begin
      if (w_found) begin
        r_valid    <= 1'b1;
        r_grant_id <= w_sel;
        r_owner    <= w_sel;
        r_credit   <= w_next_credit;
      end else begin
        r_valid  <= 1'b0;
        r_credit <= '0;
      end
    end
  end

  // Payload is qualified by r_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_adv && w_found) r_data <= w_head[w_sel];
  end

  assign intf_out.valid = r_valid;
  assign intf_out.data  = r_data;
  assign grant_id       = r_grant_id;
  assign buf_empty      = w_empty;

endmodule

// File: tb/tb_meta_intf_wrr_arbiter.sv
// Bench for meta_intf_wrr_arbiter: queue-based reference model feeding a scoreboard, checked by a negedge monitor.
module tb_meta_intf_wrr_arbiter;
  import stf_arb_pkg::*;

  localparam int N = 4;
  localparam int D = 4;

  typedef struct packed {
    logic [1:0]  gid;
    logic [63:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [N-1:0] in_valid;
  logic [63:0] in_data [N];
  logic [N-1:0] dut_rdy;
  logic        out_ready;
  arb_mode_t   mode;
  logic [15:0] weights;
  logic [1:0]  grant_id;
  logic [N-1:0] buf_empty;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference model state
  logic [63:0] mq [N][$];
  beat_t       expq[$];
  int          m_owner;
  int          m_credit;
  bit          m_valid;
  bit          m_rdy [N];
  int          m_sel;
  int          gid_log[$];
  int          tag_log[$];

  metaIntf #(.STYPE(logic [63:0])) in_if [N] ();
  metaIntf #(.STYPE(logic [63:0])) out_if ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign in_if[g].valid = in_valid[g];
    assign in_if[g].data  = in_data[g];
    assign dut_rdy[g]     = in_if[g].ready;
  end
  assign out_if.ready = out_ready;

  meta_intf_wrr_arbiter #(
    .N_INTERFACES(N), .STYPE(logic [63:0]), .BUF_DEPTH(D), .WEIGHT_BITS(4)
  ) dut (
    .clk(clk), .rst(rst), .intf_in(in_if), .intf_out(out_if),
    .mode(mode), .weights(weights), .grant_id(grant_id), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh_data();
    for (int i = 0; i < N; i++) in_data[i] = {8'(i), 24'(cyc), 32'($urandom)};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    refresh_data();
  endtask

  // Reference model: per-input queues and the arbitration rules, evaluated at each clock edge.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      expq.delete();
      m_owner = N - 1; m_credit = 0; m_valid = 0;
    end else begin
      for (int i = 0; i < N; i++) m_rdy[i] = (mq[i].size() < D);
      if (!m_valid || out_ready) begin
        m_sel = -1;
        if (mode == ARB_PRIO) begin
          for (int i = N - 1; i >= 0; i--) if (mq[i].size() > 0) m_sel = i;
          if (m_sel >= 0) begin m_owner = m_sel; m_credit = 0; end
        end else if (m_credit > 0 && mq[m_owner].size() > 0) begin
          m_sel = m_owner;
          m_credit = m_credit - 1;
        end else begin
          for (int k = 1; k <= N && m_sel < 0; k++)
            if (mq[(m_owner + k) % N].size() > 0) m_sel = (m_owner + k) % N;
          if (m_sel >= 0) begin
            m_owner  = m_sel;
            m_credit = (weights[m_sel*4 +: 4] == 0) ? 0 : int'(weights[m_sel*4 +: 4]) - 1;
          end
        end
        if (m_sel >= 0) begin
          expq.push_back({2'(m_sel), mq[m_sel].pop_front()});
          m_valid = 1;
        end else begin
          m_valid = 0; m_credit = 0;
        end
      end
      for (int i = 0; i < N; i++) if (in_valid[i] && m_rdy[i]) mq[i].push_back(in_data[i]);
    end
  end

  // Monitor: compares DUT outputs against the scoreboard away from the active edge.
  initial forever begin
    @(negedge clk);
    check("out_valid", 64'(out_if.valid), 64'(m_valid));
    for (int i = 0; i < N; i++) begin
      check($sformatf("in_ready[%0d]", i), 64'(dut_rdy[i]), 64'(mq[i].size() < D));
      check($sformatf("buf_empty[%0d]", i), 64'(buf_empty[i]), 64'(mq[i].size() == 0));
    end
    if (out_if.valid) begin
      if (expq.size() == 0) check("out_unexpected_valid", 64'(out_if.valid), 64'd0);
      else begin
        check("out_data", out_if.data, expq[0].data);
        check("out_grant_id", 64'(grant_id), 64'(expq[0].gid));
        if (out_ready) begin
          gid_log.push_back(int'(grant_id));
          tag_log.push_back(int'(out_if.data[55:32]));
          void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    int pat [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    int idx;
    int rel_cyc;
    bit seen3;
    bit hit;
    rst = 1'b1; in_valid = '1; out_ready = 1'b1; mode = ARB_WRR;
    weights = {4'd4, 4'd3, 4'd2, 4'd1};
    refresh_data();

    // reset held 3 cycles with all inputs valid
    repeat (3) step();
    check("rst_out_valid", 64'(out_if.valid), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_ready", 64'(dut_rdy), 64'hf);
    check("rst_buf_empty", 64'(buf_empty), 64'hf);
    rst = 1'b0;
    gid_log.delete();
    step();
    check("lat_release_plus1_valid", 64'(out_if.valid), 64'd0);
    step();
    check("lat_release_plus2_valid", 64'(out_if.valid), 64'd1);

    // WRR with weights 1,2,3,4 all backlogged
    for (int t = 0; t < 60 && gid_log.size() < 20; t++) step();
    check("wrr_log_size", 64'(gid_log.size() >= 20), 64'd1);
    for (int k = 0; k < 20 && k < gid_log.size(); k++)
      check($sformatf("wrr_seq[%0d]", k), 64'(gid_log[k]), 64'(pat[k % 10]));

    // backpressure: output stalled for 5 cycles
    out_ready = 1'b0;
    repeat (5) step();
    check("stall_ready_all_low", 64'(dut_rdy), 64'h0);
    check("stall_valid_held", 64'(out_if.valid), 64'd1);
    out_ready = 1'b1;
    repeat (10) step();

    // sparse: only input 2
    in_valid = '0; repeat (30) step();
    weights = 16'h1111; in_valid = 4'b0100;
    repeat (4) step();
    for (int t = 0; t < 12; t++) begin
      check("sparse_valid", 64'(out_if.valid), 64'd1);
      check("sparse_gid", 64'(grant_id), 64'd2);
      step();
    end

    // PRIO with inputs 1 and 3, then switch to WRR
    in_valid = '0; repeat (20) step();
    mode = ARB_PRIO; in_valid = 4'b1010; gid_log.delete();
    repeat (12) step();
    foreach (gid_log[k]) check("prio_gid_1", 64'(gid_log[k]), 64'd1);
    mode = ARB_WRR;
    idx = gid_log.size();
    repeat (4) step();
    check("wrr_switch_log_size", 64'(gid_log.size() > idx + 1), 64'd1);
    if (gid_log.size() > idx + 1) check("wrr_switch_gid_ge2", 64'(gid_log[idx+1] >= 2), 64'd1);

    // PRIO: input 1 stops, its FIFO drains, then input 3 takes over
    mode = ARB_PRIO; repeat (6) step();
    idx = gid_log.size();
    in_valid = 4'b1000;
    repeat (10) step();
    seen3 = 0;
    for (int k = idx; k < gid_log.size(); k++) begin
      check("prio_no_1_after_3", 64'(seen3 && gid_log[k] == 1), 64'd0);
      if (gid_log[k] == 3) seen3 = 1;
    end
    check("prio_tail_is_3", 64'(gid_log[gid_log.size()-1]), 64'd3);

    // mid-burst reset while input 3 holds credit 2
    in_valid = '0; repeat (20) step();
    mode = ARB_WRR; weights = 16'h4111; in_valid = 4'b1000;
    hit = 0;
    for (int t = 0; t < 40 && !hit; t++) begin
      step();
      hit = (m_valid && m_owner == 3 && m_credit == 2);
    end
    check("wait_credit2", 64'(hit), 64'd1);
    in_valid = '1; rst = 1'b1;
    repeat (2) step();
    check("midrst_out_valid", 64'(out_if.valid), 64'd0);
    rst = 1'b0; rel_cyc = cyc; gid_log.delete(); tag_log.delete();
    for (int t = 0; t < 10 && gid_log.size() < 4; t++) step();
    check("midrst_log_size", 64'(gid_log.size() >= 4), 64'd1);
    if (gid_log.size() > 0) check("midrst_first_gid", 64'(gid_log[0]), 64'd0);
    foreach (tag_log[k]) check("midrst_fresh_data", 64'(tag_log[k] >= (rel_cyc & 24'hffffff)), 64'd1);

    // randomized traffic, modes and weights
    for (int t = 0; t < 400; t++) begin
      if (t % 50 == 0) begin
        weights = 16'($urandom);
        mode = ($urandom_range(0, 3) == 0) ? ARB_PRIO : ARB_WRR;
      end
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = '0; out_ready = 1'b1;
    repeat (30) step();
    check("drain_scoreboard_empty", 64'(expq.size()), 64'd0);
    check("drain_out_valid", 64'(out_if.valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
